id_ex_pipe: RTL

- ID/EX pipeline register of the 5-stage MIPS pipeline CPU.
- Captures decode-stage outputs (sign/zero-extended immediate, register operands, register indices, control bits, PC+4) and presents them to EX one cycle later.
- Contains load-use hazard detection: inserts a bubble and stalls PC and IF/ID.
- Supports a branch flush from EX, a downstream hold, and a saturating bubble counter for performance monitoring.

---
 rtl/pipeline_pkg.sv | 29 ++
 rtl/hazard_detect.sv | 23 ++
 rtl/id_ex_pipe.sv | 105 ++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// Shared constants for the MIPS pipeline: opcodes, ID/EX control-bit layout
// and the NOP control word used when a bubble is inserted.
package pipeline_pkg;

  localparam logic [5:0] OP_R_TYPE = 6'b000000;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SW     = 6'b101011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_ORI    = 6'b001101;

  // Control word layout: {reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst, alu_op[2:0]}
  localparam int CTRL_W          = 9;
  localparam int CTRL_REG_WRITE  = 8;
  localparam int CTRL_MEM_READ   = 7;
  localparam int CTRL_MEM_WRITE  = 6;
  localparam int CTRL_MEM_TO_REG = 5;
  localparam int CTRL_ALU_SRC    = 4;
  localparam int CTRL_REG_DST    = 3;
  localparam int CTRL_ALU_OP_MSB = 2;
  localparam int CTRL_ALU_OP_LSB = 0;

  localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

  function automatic logic is_load(input logic [CTRL_W-1:0] ctrl);
    return ctrl[CTRL_MEM_READ];
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: flags when the load in EX writes a register the
// ID instruction reads. Register $0 never creates a dependency.
module hazard_detect #(
  parameter int REG_AW = 5
) (
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  output logic              hz
);

  logic rs_match;
  logic rt_match;

  assign rs_match = (ex_rt == id_rs);
  assign rt_match = id_uses_rt & (ex_rt == id_rt);
  assign hz = ex_valid & ex_mem_read & (ex_rt != '0) & (rs_match | rt_match) & id_valid;

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush,
// downstream hold and a saturating count of hazard bubbles.
module id_ex_pipe
  import pipeline_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] ext_immed_in,
  input  logic [DATA_W-1:0] rs_data_in,
  input  logic [DATA_W-1:0] rt_data_in,
  input  logic [DATA_W-1:0] pc_plus4_in,
  input  logic [REG_AW-1:0] rs_in,
  input  logic [REG_AW-1:0] rt_in,
  input  logic [REG_AW-1:0] rd_in,
  input  logic              uses_rt_in,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic              id_valid_in,
  input  logic              flush_in,
  input  logic              ex_hold_in,
  output logic [DATA_W-1:0] ext_immed_out,
  output logic [DATA_W-1:0] rs_data_out,
  output logic [DATA_W-1:0] rt_data_out,
  output logic [DATA_W-1:0] pc_plus4_out,
  output logic [REG_AW-1:0] rs_out,
  output logic [REG_AW-1:0] rt_out,
  output logic [REG_AW-1:0] rd_out,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic              valid_out,
  output logic              stall_out,
  output logic [CNT_W-1:0]  bubble_cnt_out
);

  typedef struct packed {
    logic [DATA_W-1:0] ext_immed;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] pc_plus4;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic [CTRL_W-1:0] ctrl;
    logic              valid;
  } slot_t;

  slot_t            slot_reg, slot_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             hz;

  hazard_detect #(.REG_AW(REG_AW)) u_hazard (
    .ex_valid    (slot_reg.valid),
    .ex_mem_read (is_load(slot_reg.ctrl)),
    .ex_rt       (slot_reg.rt),
    .id_valid    (id_valid_in),
    .id_rs       (rs_in),
    .id_rt       (rt_in),
    .id_uses_rt  (uses_rt_in),
    .hz          (hz)
  );

  // A taken branch in EX kills the ID instruction, so its hazard is moot.
  assign stall_out = ~rst & (ex_hold_in | (hz & ~flush_in));

  always_comb begin
    slot_next = slot_reg;
    cnt_next  = cnt_reg;
    if (!ex_hold_in) begin
      if (flush_in || hz) begin
        slot_next      = '0;
        slot_next.ctrl = CTRL_NOP;
        if (!flush_in && cnt_reg != '1)
          cnt_next = cnt_reg + CNT_W'(1);
      end else begin
        slot_next = '{ext_immed: ext_immed_in, rs_data: rs_data_in, rt_data: rt_data_in,
                      pc_plus4: pc_plus4_in, rs: rs_in, rt: rt_in, rd: rd_in,
                      ctrl: ctrl_in, valid: id_valid_in};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_reg <= '0;
      cnt_reg  <= '0;
    end else begin
      slot_reg <= slot_next;
      cnt_reg  <= cnt_next;
    end
  end

  assign ext_immed_out  = slot_reg.ext_immed;
  assign rs_data_out    = slot_reg.rs_data;
  assign rt_data_out    = slot_reg.rt_data;
  assign pc_plus4_out   = slot_reg.pc_plus4;
  assign rs_out         = slot_reg.rs;
  assign rt_out         = slot_reg.rt;
  assign rd_out         = slot_reg.rd;
  assign ctrl_out       = slot_reg.ctrl;
  assign valid_out      = slot_reg.valid;
  assign bubble_cnt_out = cnt_reg;

endmodule
